// File: rtl/note_ram_sequencer_if.sv
// RAM and audio-side signals of the note sequencer.
// The master side is the sequencer; the slave side is the RAM plus audio block.
interface note_ram_sequencer_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] note_out;
   logic              note_valid;
   logic              note_ready;

   modport master (
      output ram_addr, ram_wren, ram_wdata, note_out, note_valid,
      input  ram_rdata, note_ready
   );

   modport slave (
      input  ram_addr, ram_wren, ram_wdata, note_out, note_valid,
      output ram_rdata, note_ready
   );
endinterface

// File: rtl/note_ram_sequencer.sv
// Records one note per tempo tick into the note RAM and replays the song to audio
// through a valid/ready handshake, paced by the same tick.
module note_ram_sequencer #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start_rec,
   input  logic                 start_play,
   input  logic                 stop,
   input  logic                 tick,
   input  logic [DATA_W-1:0]    note_in,
   note_ram_sequencer_if.master bus,
   output logic [ADDR_W:0]      song_len,
   output logic                 busy,
   output logic [2:0]           state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REC     = 3'd1,
      REC_WR  = 3'd2,
      P_ISSUE = 3'd3,
      P_LATCH = 3'd4,
      P_OUT   = 3'd5,
      P_HOLD  = 3'd6
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            st;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   song_len_r;
   logic [DATA_W-1:0] note_out_r;
   logic [DATA_W-1:0] wdata_r;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st         <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         song_len_r <= '0;
         note_out_r <= '0;
         wdata_r    <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (start_rec) begin
                  st     <= REC;
                  wr_ptr <= '0;
               end else if (start_play && song_len_r != '0) begin
                  st     <= P_ISSUE;
                  rd_ptr <= '0;
               end
            end
            REC: begin
               // stop has priority: a tick landing with stop is discarded
               if (stop) begin
                  st         <= IDLE;
                  song_len_r <= {1'b0, wr_ptr};
               end else if (tick) begin
                  wdata_r <= note_in;
                  st      <= REC_WR;
               end
            end
            REC_WR: begin
               wr_ptr <= wr_ptr + 1'b1;
               // wide add so a write to the last address yields the full depth
               if (stop || wr_ptr == LAST_ADDR) begin
                  song_len_r <= {1'b0, wr_ptr} + 1'b1;
                  st         <= IDLE;
               end else begin
                  st <= REC;
               end
            end
            default: begin
               if (stop) begin
                  st         <= IDLE;
                  note_out_r <= '0;
               end else begin
                  case (st)
                     P_ISSUE: st <= P_LATCH;
                     P_LATCH: begin
                        note_out_r <= bus.ram_rdata;
                        st         <= P_OUT;
                     end
                     P_OUT: if (bus.note_ready) st <= P_HOLD;
                     P_HOLD: begin
                        if (tick) begin
                           rd_ptr <= rd_ptr + 1'b1;
                           if ({1'b0, rd_ptr} + 1'b1 == song_len_r) begin
                              st         <= IDLE;
                              note_out_r <= '0;
                           end else begin
                              st <= P_ISSUE;
                           end
                        end
                     end
                     default: st <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   assign bus.ram_addr   = (st == REC || st == REC_WR) ? wr_ptr :
                           (st == IDLE)                ? '0     : rd_ptr;
   assign bus.ram_wren   = (st == REC_WR);
   assign bus.ram_wdata  = wdata_r;
   assign bus.note_out   = note_out_r;
   assign bus.note_valid = (st == P_OUT);
   assign song_len       = song_len_r;
   assign busy           = (st != IDLE);
   assign state          = st;

endmodule
